// File: rtl/tlb_op_ctrl.sv
// ---------------------------------------------------------------------------
// tlb_op_ctrl
// Sequences the CP0 TLB instructions (TLBP, TLBR, TLBWI, TLBWR) against the
// shared TLB array's read/write/probe port. It sits between the MEM-stage CP0
// logic and the TLB, owns the CP0 Random counter, and writes probe/read
// results back to CP0.
//
// Each op takes three cycles: IDLE (accept) -> EXEC (TLB access) -> WB
// (CP0 write-back, done pulse). busy stalls the pipeline while an op is in
// flight. done lets the front end flush after TLB writes.
//
// Optional feature macro: TLBCTRL_WIRED_EN
//   defined   : Random lower bound comes from cp0_wired; cp0_wired_we resets
//               Random to the top entry.
//   undefined : cp0_wired / cp0_wired_we are ignored; Random cycles over all
//               entries.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   op_valid/op_type/op_ready request handshake (00 P, 01 R, 10 WI, 11 WR)
//   busy, done                stall level, 1-cycle completion pulse
//   cp0_index/entry_hi/lo0/lo1  CP0 sources latched at accept
//   cp0_wired, cp0_wired_we   Wired register and its write strobe
//   tlb_rw_index/tlb_rw_we    TLB entry select and write enable
//   tlb_entry_*_o             TLB write data / probe key
//   tlb_entry_*_i             TLB read data at tlb_rw_index
//   tlb_p_index_i             TLB probe result {miss, 0.., which}
//   cp0_index_we/wdata        probe result write-back
//   cp0_entry_we, cp0_*_wdata TLBR result write-back
//   cp0_random                CP0 Random, zero-extended
// ---------------------------------------------------------------------------
module tlb_op_ctrl #(
    parameter int TLB_ENTRY_NUM = 16,
    parameter int TLB_IDX_W     = $clog2(TLB_ENTRY_NUM)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 op_valid,
    input  logic [1:0]           op_type,
    output logic                 op_ready,
    output logic                 busy,
    output logic                 done,
    input  logic [31:0]          cp0_index,
    input  logic [31:0]          cp0_entry_hi,
    input  logic [31:0]          cp0_entry_lo0,
    input  logic [31:0]          cp0_entry_lo1,
    input  logic [31:0]          cp0_wired,
    input  logic                 cp0_wired_we,
    output logic [TLB_IDX_W-1:0] tlb_rw_index,
    output logic                 tlb_rw_we,
    output logic [31:0]          tlb_entry_hi_o,
    output logic [31:0]          tlb_entry_lo0_o,
    output logic [31:0]          tlb_entry_lo1_o,
    input  logic [31:0]          tlb_entry_hi_i,
    input  logic [31:0]          tlb_entry_lo0_i,
    input  logic [31:0]          tlb_entry_lo1_i,
    input  logic [31:0]          tlb_p_index_i,
    output logic                 cp0_index_we,
    output logic [31:0]          cp0_index_wdata,
    output logic                 cp0_entry_we,
    output logic [31:0]          cp0_hi_wdata,
    output logic [31:0]          cp0_lo0_wdata,
    output logic [31:0]          cp0_lo1_wdata,
    output logic [31:0]          cp0_random
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    localparam logic [1:0] OP_TLBP  = 2'b00;
    localparam logic [1:0] OP_TLBR  = 2'b01;

    localparam logic [TLB_IDX_W-1:0] RANDOM_TOP = TLB_IDX_W'(TLB_ENTRY_NUM - 1);

    state_t                state_q, state_d;
    logic [1:0]            opType_q;
    logic [TLB_IDX_W-1:0]  index_q;
    logic [31:0]           hi_q, lo0_q, lo1_q;
    logic [31:0]           rdHi_q, rdLo0_q, rdLo1_q;
    logic [31:0]           probe_q;
    logic [TLB_IDX_W-1:0]  random_q, random_d;
    logic                  accept;
    logic                  unusedBits;

    assign accept = (state_q == ST_IDLE) && op_valid;

    // Only the low index bits of Index/Wired matter; the rest are parked here.
    assign unusedBits = ^{cp0_index[31:TLB_IDX_W], cp0_wired, cp0_wired_we};

    // State register for the three-step op sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: every op walks IDLE -> EXEC -> WB -> IDLE with no waits.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (op_valid) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Snapshot the op and its CP0 operands at accept so CP0 changes made
    // while the op is in flight cannot disturb it. TLBWR takes Random as
    // its index at this same instant.
    always_ff @(posedge clk) begin
        if (rst) begin
            opType_q <= '0;
            index_q  <= '0;
            hi_q     <= '0;
            lo0_q    <= '0;
            lo1_q    <= '0;
        end else if (accept) begin
            opType_q <= op_type;
            index_q  <= (op_type == 2'b11) ? random_q : cp0_index[TLB_IDX_W-1:0];
            hi_q     <= cp0_entry_hi;
            lo0_q    <= cp0_entry_lo0;
            lo1_q    <= cp0_entry_lo1;
        end
    end

    // Capture the TLB response during EXEC; it is replayed to CP0 in WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdHi_q  <= '0;
            rdLo0_q <= '0;
            rdLo1_q <= '0;
            probe_q <= '0;
        end else if (state_q == ST_EXEC) begin
            if (opType_q == OP_TLBR) begin
                rdHi_q  <= tlb_entry_hi_i;
                rdLo0_q <= tlb_entry_lo0_i;
                rdLo1_q <= tlb_entry_lo1_i;
            end
            if (opType_q == OP_TLBP) begin
                probe_q <= tlb_p_index_i;
            end
        end
    end

    // Random counts down every cycle and wraps to the top entry once it
    // reaches its lower bound. With Wired support, a Wired write restarts
    // it from the top, and a bound at or above the top pins it there.
    always_comb begin
        random_d = random_q - 1'b1;
`ifdef TLBCTRL_WIRED_EN
        if (cp0_wired_we) begin
            random_d = RANDOM_TOP;
        end else if ((cp0_wired[TLB_IDX_W-1:0] >= RANDOM_TOP) ||
                     (random_q <= cp0_wired[TLB_IDX_W-1:0])) begin
            random_d = RANDOM_TOP;
        end
`else
        if (random_q == '0) begin
            random_d = RANDOM_TOP;
        end
`endif
    end

    // Random register.
    always_ff @(posedge clk) begin
        if (rst) begin
            random_q <= RANDOM_TOP;
        end else begin
            random_q <= random_d;
        end
    end

    // Strobes are qualified with rst so that a reset landing in EXEC or WB
    // suppresses the TLB write, the CP0 write and the done pulse of that op.
    assign op_ready        = (state_q == ST_IDLE);
    assign busy            = (state_q != ST_IDLE);
    assign done            = !rst && (state_q == ST_WB);
    assign tlb_rw_we       = !rst && (state_q == ST_EXEC) && opType_q[1];
    assign cp0_index_we    = done && (opType_q == OP_TLBP);
    assign cp0_entry_we    = done && (opType_q == OP_TLBR);

    assign tlb_rw_index    = index_q;
    assign tlb_entry_hi_o  = hi_q;
    assign tlb_entry_lo0_o = lo0_q;
    assign tlb_entry_lo1_o = lo1_q;

    assign cp0_index_wdata = probe_q;
    assign cp0_hi_wdata    = rdHi_q;
    assign cp0_lo0_wdata   = rdLo0_q;
    assign cp0_lo1_wdata   = rdLo1_q;
    assign cp0_random      = 32'(random_q);

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tlb_op_ctrl
// Directed bench for tlb_op_ctrl with a small TLB array model on the rw/probe
// port. Issued ops push their expected TLB write and CP0 write-back into
// queues; a negedge monitor pops and compares whenever the DUT raises
// tlb_rw_we or done. Wired tests are selected with TLBCTRL_WIRED_EN.
// ---------------------------------------------------------------------------
module tb_tlb_op_ctrl;

    typedef struct packed {
        int          cyc;
        logic [3:0]  idx;
        logic [31:0] hi;
        logic [31:0] lo0;
        logic [31:0] lo1;
    } wrExp_t;

    typedef struct packed {
        int          cyc;
        logic        idxWe;
        logic        entWe;
        logic [31:0] idxData;
        logic [31:0] hi;
        logic [31:0] lo0;
        logic [31:0] lo1;
    } doneExp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0;
    logic [1:0]  op_type = 2'b00;
    logic        op_ready, busy, done;
    logic [31:0] cp0_index = '0, cp0_entry_hi = '0, cp0_entry_lo0 = '0, cp0_entry_lo1 = '0;
    logic [31:0] cp0_wired = '0;
    logic        cp0_wired_we = 1'b0;
    logic [3:0]  tlb_rw_index;
    logic        tlb_rw_we;
    logic [31:0] tlb_entry_hi_o, tlb_entry_lo0_o, tlb_entry_lo1_o;
    logic [31:0] tlb_entry_hi_i, tlb_entry_lo0_i, tlb_entry_lo1_i;
    logic [31:0] tlb_p_index_i;
    logic        cp0_index_we, cp0_entry_we;
    logic [31:0] cp0_index_wdata, cp0_hi_wdata, cp0_lo0_wdata, cp0_lo1_wdata;
    logic [31:0] cp0_random;

    int checks = 0;
    int fails = 0;
    int cycleCount = 0;

    wrExp_t   writeQ[$];
    doneExp_t doneQ[$];

    logic [31:0] tlbHi[16];
    logic [31:0] tlbLo0[16];
    logic [31:0] tlbLo1[16];
    logic [15:0] tlbValid = '0;

    tlb_op_ctrl #(.TLB_ENTRY_NUM(16), .TLB_IDX_W(4)) dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_type(op_type), .op_ready(op_ready),
        .busy(busy), .done(done),
        .cp0_index(cp0_index), .cp0_entry_hi(cp0_entry_hi),
        .cp0_entry_lo0(cp0_entry_lo0), .cp0_entry_lo1(cp0_entry_lo1),
        .cp0_wired(cp0_wired), .cp0_wired_we(cp0_wired_we),
        .tlb_rw_index(tlb_rw_index), .tlb_rw_we(tlb_rw_we),
        .tlb_entry_hi_o(tlb_entry_hi_o), .tlb_entry_lo0_o(tlb_entry_lo0_o),
        .tlb_entry_lo1_o(tlb_entry_lo1_o),
        .tlb_entry_hi_i(tlb_entry_hi_i), .tlb_entry_lo0_i(tlb_entry_lo0_i),
        .tlb_entry_lo1_i(tlb_entry_lo1_i), .tlb_p_index_i(tlb_p_index_i),
        .cp0_index_we(cp0_index_we), .cp0_index_wdata(cp0_index_wdata),
        .cp0_entry_we(cp0_entry_we), .cp0_hi_wdata(cp0_hi_wdata),
        .cp0_lo0_wdata(cp0_lo0_wdata), .cp0_lo1_wdata(cp0_lo1_wdata),
        .cp0_random(cp0_random)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // TLB array model: synchronous write, combinational read and VPN2 probe.
    always @(posedge clk) begin
        if (tlb_rw_we === 1'b1) begin
            tlbHi[tlb_rw_index]    <= tlb_entry_hi_o;
            tlbLo0[tlb_rw_index]   <= tlb_entry_lo0_o;
            tlbLo1[tlb_rw_index]   <= tlb_entry_lo1_o;
            tlbValid[tlb_rw_index] <= 1'b1;
        end
    end

    assign tlb_entry_hi_i  = tlbValid[tlb_rw_index] ? tlbHi[tlb_rw_index]  : 32'h0;
    assign tlb_entry_lo0_i = tlbValid[tlb_rw_index] ? tlbLo0[tlb_rw_index] : 32'h0;
    assign tlb_entry_lo1_i = tlbValid[tlb_rw_index] ? tlbLo1[tlb_rw_index] : 32'h0;

    always_comb begin
        tlb_p_index_i = 32'h8000_0000;
        for (int e = 15; e >= 0; e--) begin
            if (tlbValid[e] && (tlbHi[e][31:13] == tlb_entry_hi_o[31:13])) begin
                tlb_p_index_i = 32'(e);
            end
        end
    end

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT writes the TLB or finishes.
    always @(negedge clk) begin
        if (tlb_rw_we === 1'b1) begin
            if (writeQ.size() == 0) begin
                checkVal("unexpected_tlb_write", 32'(tlb_rw_index), 32'hFFFF_FFFF);
            end else begin
                wrExp_t w;
                w = writeQ.pop_front();
                checkVal("write_cycle", 32'(cycleCount), 32'(w.cyc));
                checkVal("write_index", 32'(tlb_rw_index), 32'(w.idx));
                checkVal("write_hi", tlb_entry_hi_o, w.hi);
                checkVal("write_lo0", tlb_entry_lo0_o, w.lo0);
                checkVal("write_lo1", tlb_entry_lo1_o, w.lo1);
            end
        end
        if (done === 1'b1) begin
            if (doneQ.size() == 0) begin
                checkVal("unexpected_done", 32'(done), 32'h0);
            end else begin
                doneExp_t d;
                d = doneQ.pop_front();
                checkVal("done_cycle", 32'(cycleCount), 32'(d.cyc));
                checkVal("cp0_index_we", 32'(cp0_index_we), 32'(d.idxWe));
                checkVal("cp0_entry_we", 32'(cp0_entry_we), 32'(d.entWe));
                if (d.idxWe) checkVal("cp0_index_wdata", cp0_index_wdata, d.idxData);
                if (d.entWe) begin
                    checkVal("cp0_hi_wdata", cp0_hi_wdata, d.hi);
                    checkVal("cp0_lo0_wdata", cp0_lo0_wdata, d.lo0);
                    checkVal("cp0_lo1_wdata", cp0_lo1_wdata, d.lo1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for op_ready, presents the op, returns the accept cycle.
    task automatic applyStimulus(input logic [1:0] t, input logic [31:0] idx,
                                 input logic [31:0] hi, input logic [31:0] lo0,
                                 input logic [31:0] lo1, input bit keepValid,
                                 output int acc);
        int n = 0;
        while (op_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checkVal("issue_op_ready", 32'(op_ready), 32'h1);
        op_valid      = 1'b1;
        op_type       = t;
        cp0_index     = idx;
        cp0_entry_hi  = hi;
        cp0_entry_lo0 = lo0;
        cp0_entry_lo1 = lo1;
        tick();
        acc = cycleCount;
        if (!keepValid) op_valid = 1'b0;
    endtask

    task automatic expectWrite(input int acc, input logic [3:0] idx, input logic [31:0] hi,
                               input logic [31:0] lo0, input logic [31:0] lo1);
        writeQ.push_back('{cyc: acc, idx: idx, hi: hi, lo0: lo0, lo1: lo1});
    endtask

    task automatic expectDone(input int acc, input logic iw, input logic ew, input logic [31:0] id,
                              input logic [31:0] hi, input logic [31:0] lo0, input logic [31:0] lo1);
        doneQ.push_back('{cyc: acc + 1, idxWe: iw, entWe: ew, idxData: id, hi: hi, lo0: lo0, lo1: lo1});
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkVal(name, act, exp);
    endtask

    task automatic resetDut();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int acc, acc1, acc2, acc3, n;
        logic [31:0] idleRandom[5];
        idleRandom[0] = 15; idleRandom[1] = 14; idleRandom[2] = 13;
        idleRandom[3] = 12; idleRandom[4] = 11;

        // 1: reset state and idle Random countdown
        rst = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset_op_ready", 32'(op_ready), 32'h1);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_done", 32'(done), 32'h0);
        checkOutput("reset_tlb_rw_we", 32'(tlb_rw_we), 32'h0);
        checkOutput("reset_cp0_we", 32'({cp0_index_we, cp0_entry_we}), 32'h0);
        checkOutput("reset_index_wdata", cp0_index_wdata, 32'h0);
        checkOutput("reset_rw_index", 32'(tlb_rw_index), 32'h0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("idle_random", cp0_random, idleRandom[i]);
            tick();
        end

        // 2: TLBWI then TLBR of the same entry; Index change in EXEC is ignored
        applyStimulus(2'b10, 32'd5, 32'h0040_0012, 32'h0000_1016, 32'h0000_1056, 1'b0, acc);
        expectWrite(acc, 4'd5, 32'h0040_0012, 32'h0000_1016, 32'h0000_1056);
        expectDone(acc, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        cp0_index = 32'd9;
        checkOutput("busy_in_exec", 32'(busy), 32'h1);
        checkOutput("ready_in_exec", 32'(op_ready), 32'h0);
        applyStimulus(2'b01, 32'd5, 32'h0, 32'h0, 32'h0, 1'b0, acc);
        expectDone(acc, 1'b0, 1'b1, 32'h0, 32'h0040_0012, 32'h0000_1016, 32'h0000_1056);

        // 3: TLBP hit on entry 5 and miss on unmapped VPN
        applyStimulus(2'b00, 32'd0, 32'h0040_0012, 32'h0, 32'h0, 1'b0, acc);
        expectDone(acc, 1'b1, 1'b0, 32'h0000_0005, 32'h0, 32'h0, 32'h0);
        applyStimulus(2'b00, 32'd0, 32'h1234_0000, 32'h0, 32'h0, 1'b0, acc);
        expectDone(acc, 1'b1, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 32'h0);

        // 4: TLBWR accepted while Random = 0 writes entry 0; Random wraps to 15
        tick();
        tick();
        n = 0;
        while (cp0_random !== 32'h0 && n < 40) begin
            tick();
            n++;
        end
        checkOutput("random_reaches_zero", cp0_random, 32'h0);
        applyStimulus(2'b11, 32'd7, 32'h0080_0000, 32'h0000_2222, 32'h0000_3333, 1'b0, acc);
        expectWrite(acc, 4'd0, 32'h0080_0000, 32'h0000_2222, 32'h0000_3333);
        expectDone(acc, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        checkOutput("random_wrap", cp0_random, 32'd15);
        applyStimulus(2'b01, 32'd0, 32'h0, 32'h0, 32'h0, 1'b0, acc);
        expectDone(acc, 1'b0, 1'b1, 32'h0, 32'h0080_0000, 32'h0000_2222, 32'h0000_3333);

        // 5: back-to-back TLBWI with op_valid held high
        applyStimulus(2'b10, 32'd1, 32'h0100_0000, 32'h11, 32'h12, 1'b1, acc1);
        expectWrite(acc1, 4'd1, 32'h0100_0000, 32'h11, 32'h12);
        expectDone(acc1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        applyStimulus(2'b10, 32'd2, 32'h0120_0000, 32'h21, 32'h22, 1'b1, acc2);
        expectWrite(acc2, 4'd2, 32'h0120_0000, 32'h21, 32'h22);
        expectDone(acc2, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        applyStimulus(2'b10, 32'd3, 32'h0140_0000, 32'h31, 32'h32, 1'b0, acc3);
        expectWrite(acc3, 4'd3, 32'h0140_0000, 32'h31, 32'h32);
        expectDone(acc3, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        checkOutput("b2b_gap_1", 32'(acc2 - acc1), 32'd3);
        checkOutput("b2b_gap_2", 32'(acc3 - acc2), 32'd3);
        applyStimulus(2'b00, 32'd0, 32'h0120_0abc, 32'h0, 32'h0, 1'b0, acc);
        expectDone(acc, 1'b1, 1'b0, 32'h0000_0002, 32'h0, 32'h0, 32'h0);

        // 5b: reset during EXEC of a TLBWI aborts it (no expectations pushed)
        applyStimulus(2'b10, 32'd7, 32'h0200_0000, 32'h71, 32'h72, 1'b0, acc);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort_op_ready", 32'(op_ready), 32'h1);
        checkOutput("abort_busy", 32'(busy), 32'h0);
        checkOutput("abort_random", cp0_random, 32'd15);
        tick();
        tick();
        checkOutput("abort_entry7_unwritten", 32'(tlbValid[7]), 32'h0);

`ifdef TLBCTRL_WIRED_EN
        // 6: Wired = 4 restarts Random at 15 and bounds it at 4
        cp0_wired    = 32'd4;
        cp0_wired_we = 1'b1;
        tick();
        cp0_wired_we = 1'b0;
        checkOutput("wired_restart", cp0_random, 32'd15);
        for (int v = 14; v >= 4; v--) begin
            tick();
            checkOutput("wired_countdown", cp0_random, 32'(v));
        end
        tick();
        checkOutput("wired_wrap", cp0_random, 32'd15);
        // Wired = 15 pins Random at the top
        cp0_wired    = 32'd15;
        cp0_wired_we = 1'b1;
        tick();
        cp0_wired_we = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("wired_pinned", cp0_random, 32'd15);
            tick();
        end
        cp0_wired = 32'd0;
`else
        // 6: Wired inputs are ignored; Random walks the full range and wraps
        resetDut();
        checkOutput("nowired_start", cp0_random, 32'd15);
        cp0_wired    = 32'd4;
        cp0_wired_we = 1'b1;
        tick();
        cp0_wired_we = 1'b0;
        for (int v = 14; v >= 0; v--) begin
            checkOutput("nowired_countdown", cp0_random, 32'(v));
            tick();
        end
        checkOutput("nowired_wrap", cp0_random, 32'd15);
        cp0_wired = 32'd0;
`endif

        tick();
        tick();
        tick();
        checkOutput("write_queue_drained", 32'(writeQ.size()), 32'h0);
        checkOutput("done_queue_drained", 32'(doneQ.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout actual=running required=finished");
        $fatal(1, "[TB] time limit reached");
    end

endmodule
